// File: rtl/pad_button_debouncer_if.sv
// Pad-button signal bundle between the board pins and the debouncer.
// There is no valid/ready handshake on this bundle: btn_raw and btn_stable
// are free-running levels, and btn_pressed/btn_released/any_change are
// single-cycle event strobes that the consumer must sample every clk_2x cycle.
interface pad_button_debouncer_if #(
  parameter int BUTTON_COUNT = 7
);
  logic [BUTTON_COUNT-1:0] btn_raw;
  logic [BUTTON_COUNT-1:0] btn_stable;
  logic [BUTTON_COUNT-1:0] btn_pressed;
  logic [BUTTON_COUNT-1:0] btn_released;
  logic                    any_change;

  // Pin side drives the raw levels and observes the conditioned result.
  modport master (
    output btn_raw,
    input  btn_stable,
    input  btn_pressed,
    input  btn_released,
    input  any_change
  );

  // Debouncer side consumes the raw levels and produces the conditioned result.
  modport slave (
    input  btn_raw,
    output btn_stable,
    output btn_pressed,
    output btn_released,
    output any_change
  );
endinterface

// File: rtl/pad_button_debouncer.sv
// Per-button conditioning of the raw PCB buttons in the clk_2x domain:
// two-flop synchroniser, polarity normalisation (1 = pressed), then a
// tick-based debounce that accepts a new level only after it has disagreed
// with the current stable level for DEBOUNCE_TICKS consecutive ticks.
// A single prescaler generates the debounce tick shared by all buttons.
module pad_button_debouncer #(
  parameter int                      BUTTON_COUNT   = 7,
  parameter logic [BUTTON_COUNT-1:0] INVERT_MASK    = BUTTON_COUNT'(1),
  parameter int                      TICK_DIVIDER   = 65536,
  parameter int                      DEBOUNCE_TICKS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pad_button_debouncer_if.slave pad
);

  // A one-tick debounce would need a zero-width counter; keep at least one bit.
  localparam int PRE_W = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIVIDER - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [BUTTON_COUNT-1:0] sync0_q;
  logic [BUTTON_COUNT-1:0] sync1_q;
  logic [BUTTON_COUNT-1:0] level;

  logic [PRE_W-1:0]        presc_q;
  logic                    tick;

  logic [CNT_W-1:0]        cnt_q   [BUTTON_COUNT];
  logic [CNT_W-1:0]        cnt_nxt [BUTTON_COUNT];

  logic [BUTTON_COUNT-1:0] stable_q;
  logic [BUTTON_COUNT-1:0] stable_nxt;
  logic [BUTTON_COUNT-1:0] pressed_q;
  logic [BUTTON_COUNT-1:0] pressed_nxt;
  logic [BUTTON_COUNT-1:0] released_q;
  logic [BUTTON_COUNT-1:0] released_nxt;
  logic                    any_change_q;

  // Two-flop synchroniser. Resetting to INVERT_MASK makes every button read
  // as released after normalisation, so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync0_q <= INVERT_MASK;
      sync1_q <= INVERT_MASK;
    end else begin
      sync0_q <= pad.btn_raw;
      sync1_q <= sync0_q;
    end
  end

  // Active-low pins are flipped only after the second flop.
  assign level = sync1_q ^ INVERT_MASK;

  // Shared prescaler: free-running 0..TICK_DIVIDER-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (presc_q == PRE_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // The tick is high for exactly the last count of each prescaler period.
  assign tick = (presc_q == PRE_LAST);

  // Debounce decision per button. A match clears the counter immediately, so
  // any bounce back to the stable level restarts the whole qualification.
  // The counter stops at CNT_LAST: reaching it on a tick accepts the level.
  always_comb begin
    cnt_nxt      = cnt_q;
    stable_nxt   = stable_q;
    pressed_nxt  = '0;
    released_nxt = '0;
    for (int i = 0; i < BUTTON_COUNT; i++) begin
      if (level[i] == stable_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_nxt[i]      = '0;
          stable_nxt[i]   = level[i];
          pressed_nxt[i]  = level[i];
          released_nxt[i] = ~level[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Counter, stable-level and event registers. Events are registered on the
  // same edge as the stable level so each pulse lines up with its edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < BUTTON_COUNT; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q     <= '0;
      pressed_q    <= '0;
      released_q   <= '0;
      any_change_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_nxt;
      stable_q     <= stable_nxt;
      pressed_q    <= pressed_nxt;
      released_q   <= released_nxt;
      any_change_q <= |(pressed_nxt | released_nxt);
    end
  end

  assign pad.btn_stable   = stable_q;
  assign pad.btn_pressed  = pressed_q;
  assign pad.btn_released = released_q;
  assign pad.any_change   = any_change_q;

endmodule

// File: tb/tb_pad_button_debouncer.sv
// Bench for pad_button_debouncer with a small divider so full debounce
// latencies fit in a few dozen cycles.
module tb_pad_button_debouncer;

  localparam int         N    = 7;
  localparam logic [6:0] MASK = 7'h01;
  localparam int         TD   = 8;
  localparam int         DT   = 4;
  localparam int         W    = 3 * N + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pad_button_debouncer_if #(.BUTTON_COUNT(N)) pad ();

  pad_button_debouncer #(
    .BUTTON_COUNT  (N),
    .INVERT_MASK   (MASK),
    .TICK_DIVIDER  (TD),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .pad    (pad)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_vec;
  logic [W-1:0] exp_vec;

  // ---------------- reference model ----------------
  // Pin values seen by the last two edges, cycles since reset, and the number
  // of ticks each button has spent disagreeing with its accepted level.
  logic [6:0] m_hist[$];
  int         m_cyc;
  int         m_run[N];
  logic [6:0] m_stable;
  logic [6:0] m_press;
  logic [6:0] m_rel;

  task automatic model_edge(input logic rst, input logic [6:0] raw);
    logic [6:0] lvl;
    bit         tick;
    if (!rst) begin
      m_hist.delete();
      m_hist.push_back(MASK);
      m_hist.push_back(MASK);
      m_cyc    = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_stable = '0;
      m_press  = '0;
      m_rel    = '0;
    end else begin
      // The pin value from two edges ago is what the debounce sees now.
      lvl  = m_hist[0] ^ MASK;
      void'(m_hist.pop_front());
      m_hist.push_back(raw);
      tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) begin
        if (lvl[i] == m_stable[i]) begin
          m_run[i] = 0;
        end else if (tick) begin
          m_run[i]++;
          if (m_run[i] == DT) begin
            m_stable[i] = lvl[i];
            if (lvl[i]) m_press[i] = 1'b1;
            else        m_rel[i]   = 1'b1;
            m_run[i] = 0;
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs just after an edge, step the model at the edge, sample 1ns later.
  task automatic run_cycle(input logic rst, input logic [6:0] raw);
    reset_n     = rst;
    pad.btn_raw = raw;
    @(posedge clk);
    model_edge(rst, raw);
    exp_q.push_back({m_stable, m_press, m_rel, |(m_press | m_rel)});
    #1;
    obs_vec = {pad.btn_stable, pad.btn_pressed, pad.btn_released, pad.any_change};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit seen = 0;
    for (int c = 0; c < 3; c++) begin
      run_cycle(1'b0, 7'h01);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
    end
    for (int c = 0; c < 100; c++) begin
      run_cycle(1'b1, 7'h01);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_idle_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (pad.any_change !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_any_change got 1 want never");
    end
    n_cmp++;
    if (pad.btn_stable !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_stable got %h want 00", pad.btn_stable);
    end
  endtask

  task automatic test_clean_press();
    int lat = -1;
    int cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h09);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL press_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (pad.btn_pressed !== 7'h00) begin
        cnt++;
        if (lat < 0) lat = c;
        n_cmp++;
        if (pad.btn_pressed !== 7'h08 || pad.any_change !== 1'b1 || pad.btn_stable !== 7'h08) begin
          n_fail++;
          $display("FAIL press_pulse got p=%h a=%b s=%h want p=08 a=1 s=08",
                   pad.btn_pressed, pad.any_change, pad.btn_stable);
        end
      end
    end
    n_cmp++;
    if (lat < 27 || lat > 34) begin
      n_fail++;
      $display("FAIL press_latency got %0d want 27..34", lat);
    end
    n_cmp++;
    if (cnt !== 1) begin
      n_fail++;
      $display("FAIL press_count got %0d want 1", cnt);
    end
    lat = -1;
    cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h01);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL release_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (pad.btn_released !== 7'h00) begin
        cnt++;
        if (lat < 0) lat = c;
        n_cmp++;
        if (pad.btn_released !== 7'h08 || pad.any_change !== 1'b1 || pad.btn_stable !== 7'h00) begin
          n_fail++;
          $display("FAIL release_pulse got r=%h a=%b s=%h want r=08 a=1 s=00",
                   pad.btn_released, pad.any_change, pad.btn_stable);
        end
      end
    end
    n_cmp++;
    if (lat < 27 || lat > 34 || cnt !== 1) begin
      n_fail++;
      $display("FAIL release_latency got lat=%0d n=%0d want 27..34 n=1", lat, cnt);
    end
  endtask

  task automatic test_bounce();
    bit moved = 0;
    int lat   = -1;
    int cnt   = 0;
    for (int c = 0; c < 200; c++) begin
      run_cycle(1'b1, ((c / 10) % 2 == 0) ? 7'h21 : 7'h01);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bounce_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (pad.btn_stable[5] !== 1'b0 || pad.any_change !== 1'b0) moved = 1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_reject got change want none");
    end
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h21);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bounce_settle_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (pad.btn_pressed[5] === 1'b1) begin
        cnt++;
        if (lat < 0) lat = c;
      end
    end
    n_cmp++;
    if (cnt !== 1 || lat < 27 || lat > 34) begin
      n_fail++;
      $display("FAIL bounce_press got n=%0d lat=%0d want n=1 lat=27..34", cnt, lat);
    end
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h01);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bounce_release_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_active_low();
    int lat = -1;
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h00);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL actlow_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (lat < 0 && pad.btn_stable[0] === 1'b1) begin
        lat = c;
        n_cmp++;
        if (pad.btn_pressed !== 7'h01) begin
          n_fail++;
          $display("FAIL actlow_pulse got %h want 01", pad.btn_pressed);
        end
      end
    end
    n_cmp++;
    if (lat < 27 || lat > 34) begin
      n_fail++;
      $display("FAIL actlow_latency got %0d want 27..34", lat);
    end
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h01);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL actlow_release_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (pad.btn_stable !== 7'h00) begin
      n_fail++;
      $display("FAIL actlow_back got %h want 00", pad.btn_stable);
    end
  endtask

  task automatic test_simultaneous();
    int cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h61);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL simul_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (pad.btn_pressed !== 7'h00) begin
        cnt++;
        n_cmp++;
        if (pad.btn_pressed !== 7'h60) begin
          n_fail++;
          $display("FAIL simul_pulse got %h want 60", pad.btn_pressed);
        end
      end
    end
    n_cmp++;
    if (cnt !== 1) begin
      n_fail++;
      $display("FAIL simul_count got %0d want 1", cnt);
    end
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h01);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL simul_release_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit accepted = 0;
    int lat      = -1;
    int cnt      = 0;
    for (int c = 1; c <= 60 && !accepted; c++) begin
      run_cycle(1'b1, 7'h03);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (pad.btn_pressed[1] === 1'b1) accepted = 1;
    end
    n_cmp++;
    if (accepted !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_accept got none want press within 60");
    end
    run_cycle(1'b0, 7'h03);
    exp_vec = exp_q.pop_front();
    n_cmp++;
    if (obs_vec !== {W{1'b0}}) begin
      n_fail++;
      $display("FAIL rstmid_clear got %h want %h", obs_vec, {W{1'b0}});
    end
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h03);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_refire_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
      if (pad.btn_pressed[1] === 1'b1) begin
        cnt++;
        if (lat < 0) lat = c;
      end
    end
    n_cmp++;
    if (cnt !== 1 || lat < 27 || lat > 34) begin
      n_fail++;
      $display("FAIL rstmid_refire got n=%0d lat=%0d want n=1 lat=27..34", cnt, lat);
    end
    for (int c = 1; c <= 60; c++) begin
      run_cycle(1'b1, 7'h01);
      exp_vec = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_release_model c=%0d got %h want %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] raw;
    int         hold;
    logic       rst;
    for (int s = 0; s < 80; s++) begin
      raw  = 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        run_cycle(rst, raw);
        exp_vec = exp_q.pop_front();
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL random_model s=%0d c=%0d got %h want %h", s, c, obs_vec, exp_vec);
        end
        n_cmp++;
        if ((pad.btn_pressed & pad.btn_released) !== 7'h00) begin
          n_fail++;
          $display("FAIL random_exclusive got %h want 00", pad.btn_pressed & pad.btn_released);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n     = 1'b0;
    pad.btn_raw = 7'h01;
    test_reset();
    test_clean_press();
    test_bounce();
    test_active_low();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
